// File: rtl/axil_ram_ext_pkg.sv
// Shared constants and helpers for the AXI4-Lite scratch RAM.
package axil_ram_ext_pkg;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam int         MAX_READ_LATENCY = 4;

  // Index width for a table of 'depth' entries, never narrower than one bit.
  function automatic int word_index_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/axil_ram_ext_rd_fifo.sv
// First-word fall-through return buffer for read beats; data visible the cycle after a push.
// Caller guarantees no push when full and no pop when empty.
module axil_ram_ext_rd_fifo
  import axil_ram_ext_pkg::*;
#(
  parameter int DW    = 34,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = word_index_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr] <= wr_data;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign empty   = (count == '0);
  assign rd_data = mem_q[rd_ptr];
endmodule

// File: rtl/axil_ram_ext.sv
// AXI4-Lite slave RAM: B one cycle after AW+W both held; R READ_LATENCY cycles after AR, buffered for rready stalls.
// Optional AXIL_RAM_EXT_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of being silently dropped.
module axil_ram_ext
  import axil_ram_ext_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int MEM_DEPTH    = 2 ** (ADDR_WIDTH - $clog2(STRB_WIDTH)),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);
  localparam int SB   = $clog2(STRB_WIDTH);
  localparam int IDXW = ADDR_WIDTH - SB;
  localparam int IW   = word_index_width(MEM_DEPTH);
  localparam int FD   = READ_LATENCY + 1;
  localparam int FCW  = $clog2(FD + 1);

  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } rd_beat_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  aw_held, w_held, commit;
  logic [IDXW-1:0]       aw_idx, ar_idx;
  logic [IW-1:0]         wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  wr_ok, rd_ok;
  logic [1:0]            wr_resp, rd_resp;

  assign ar_idx  = s_axil_araddr[ADDR_WIDTH-1:SB];
  assign wr_addr = aw_idx[IW-1:0];
  assign rd_addr = ar_idx[IW-1:0];

`ifdef AXIL_RAM_EXT_ERR_RESP_EN
  assign wr_ok   = {1'b0, aw_idx} < (IDXW+1)'(MEM_DEPTH);
  assign rd_ok   = {1'b0, ar_idx} < (IDXW+1)'(MEM_DEPTH);
  assign wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = rd_ok ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_ok   = {1'b0, wr_addr} < (IW+1)'(MEM_DEPTH);
  assign rd_ok   = {1'b0, rd_addr} < (IW+1)'(MEM_DEPTH);
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, aw_idx};

  // Write side: readies depend only on held state, so a full slot frees the cycle it commits.
  assign commit         = aw_held && w_held && (!s_axil_bvalid || s_axil_bready);
  assign s_axil_awready = rst_n && (!aw_held || commit);
  assign s_axil_wready  = rst_n && (!w_held || commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:SB];
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end else if (commit) begin
        w_held <= 1'b0;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_ok)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (w_strb[i]) mem[wr_addr][8*i +: 8] <= w_data[8*i +: 8];
  end

  // Read side: array sampled at the AR edge (old data wins over a same-edge commit).
  rd_beat_t                  pipe_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0]   pipe_vld;
  logic [3:0]                inflight;
  logic [FCW-1:0]            fifo_count;
  logic                      fifo_empty, ar_hs, r_pop;
  rd_beat_t                  fifo_out;

  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign r_pop = s_axil_rvalid && s_axil_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0]      <= ar_hs;
      pipe_dat[0].resp <= rd_resp;
      pipe_dat[0].data <= rd_ok ? mem[rd_addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 4'(pipe_vld[i]);
  end

  // A beat leaving this cycle frees its slot, which keeps back-to-back reads at full rate.
  assign s_axil_arready = rst_n && (((inflight + 4'(fifo_count)) < 4'(FD)) || r_pop);

  axil_ram_ext_rd_fifo #(
    .DW    ($bits(rd_beat_t)),
    .DEPTH (FD)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_vld[READ_LATENCY-1]),
    .wr_data (pipe_dat[READ_LATENCY-1]),
    .rd_en   (r_pop),
    .rd_data (fifo_out),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_axil_rvalid = !fifo_empty;
  assign s_axil_rdata  = fifo_out.data;
  assign s_axil_rresp  = fifo_out.resp;
endmodule

// File: tb/tb_axil_ram_ext.sv
// Bench for axil_ram_ext: table of write/read vectors through a response scoreboard, plus timing corner sequences.
module tb_axil_ram_ext;
  localparam int RL = 3;

`ifdef AXIL_RAM_EXT_ERR_RESP_EN
  localparam logic [1:0]  OOR_RESP   = 2'b10;
  localparam logic [1:0]  ALIAS_RESP = 2'b10;
  localparam logic [31:0] ALIAS_DATA = 32'h0000_0000;
`else
  localparam logic [1:0]  OOR_RESP   = 2'b00;
  localparam logic [1:0]  ALIAS_RESP = 2'b00;
  localparam logic [31:0] ALIAS_DATA = 32'h7777_7777;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_axil_awaddr = '0, s_axil_araddr = '0;
  logic [2:0]  s_axil_awprot = '0, s_axil_arprot = '0;
  logic        s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_arvalid = 0;
  logic        s_axil_bready = 1, s_axil_rready = 1;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;

  always #5 clk = ~clk;

  axil_ram_ext #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(100), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; logic [3:0] strb; logic [1:0] resp; } vec_t;

  logic [1:0] b_q[$];
  rexp_t      r_q[$];
  int         tests = 0, fails = 0, r_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: a response is consumed at the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n && s_axil_bvalid && s_axil_bready) begin
      if (b_q.size() == 0) check("unexpected_b", 32'(s_axil_bvalid), 32'h0);
      else check("bresp", 32'(s_axil_bresp), 32'(b_q.pop_front()));
    end
    if (rst_n && s_axil_rvalid && s_axil_rready) begin
      r_seen++;
      if (r_q.size() == 0) check("unexpected_r", 32'(s_axil_rvalid), 32'h0);
      else begin
        rexp_t e;
        e = r_q.pop_front();
        check("rdata", s_axil_rdata, e.data);
        check("rresp", 32'(s_axil_rresp), 32'(e.resp));
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic write_op(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      aw_f = s_axil_awvalid && s_axil_awready;
      w_f  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (aw_f) begin s_axil_awvalid = 0; aw_done = 1; end
      if (w_f)  begin s_axil_wvalid = 0;  w_done = 1;  end
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    if (aw_done && w_done) b_q.push_back(resp);
    else check("write_handshake_timeout", 32'(aw_done && w_done), 32'h1);
  endtask

  task automatic read_op(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
    bit done = 0, f;
    s_axil_araddr = a; s_axil_arvalid = 1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      f = s_axil_arvalid && s_axil_arready;
      @(posedge clk); #1;
      if (f) begin s_axil_arvalid = 0; done = 1; r_q.push_back('{data: d, resp: resp}); end
    end
    s_axil_arvalid = 0;
    if (!done) check("read_handshake_timeout", 32'(done), 32'h1);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && c < 100) begin
      @(posedge clk); #1; c++;
    end
    if (b_q.size() != 0 || r_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s: %0d B and %0d R responses outstanding after timeout, expected 0", name, b_q.size(), r_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    bit   flag, saw_full, fire;
    int   issued, ostd, seen0;

    vecs.push_back('{1, 16'h0104, 32'h1234_5678, 4'hF, 2'b00});
    vecs.push_back('{1, 16'h0104, 32'h0000_AB00, 4'h2, 2'b00});
    vecs.push_back('{0, 16'h0104, 32'h1234_AB78, 4'h0, 2'b00});
    vecs.push_back('{1, 16'h0106, 32'hCAFE_F00D, 4'hC, 2'b00});
    vecs.push_back('{0, 16'h0105, 32'hCAFE_AB78, 4'h0, 2'b00});
    vecs.push_back('{1, 16'h0000, 32'h0102_0304, 4'hF, 2'b00});
    vecs.push_back('{1, 16'h0000, 32'hFFFF_FFFF, 4'h0, 2'b00});
    vecs.push_back('{0, 16'h0000, 32'h0102_0304, 4'h0, 2'b00});
    vecs.push_back('{1, 16'h018C, 32'h9999_9999, 4'hF, 2'b00});
    vecs.push_back('{0, 16'h018C, 32'h9999_9999, 4'h0, 2'b00});
    vecs.push_back('{1, 16'h0190, 32'h5555_5555, 4'hF, OOR_RESP});
    vecs.push_back('{0, 16'h0190, 32'h0000_0000, 4'h0, OOR_RESP});
    vecs.push_back('{1, 16'h0014, 32'h0000_0000, 4'hF, 2'b00});
    vecs.push_back('{1, 16'h0214, 32'h7777_7777, 4'hF, ALIAS_RESP});
    vecs.push_back('{0, 16'h0014, ALIAS_DATA,    4'h0, 2'b00});
    vecs.push_back('{0, 16'h0214, ALIAS_DATA,    4'h0, ALIAS_RESP});

    // Reset state
    #23;
    check("rst_awready", 32'(s_axil_awready), 0);
    check("rst_wready",  32'(s_axil_wready), 0);
    check("rst_arready", 32'(s_axil_arready), 0);
    check("rst_bvalid",  32'(s_axil_bvalid), 0);
    check("rst_rvalid",  32'(s_axil_rvalid), 0);
    check("rst_bresp",   32'(s_axil_bresp), 0);
    check("rst_rresp",   32'(s_axil_rresp), 0);
    check("rst_rdata",   s_axil_rdata, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Write latency: handshake edge k, bvalid visible only after k+1
    s_axil_awaddr = 16'h0100; s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(posedge clk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0; b_q.push_back(2'b00);
    @(negedge clk); check("b_lat_k", 32'(s_axil_bvalid), 0);
    @(negedge clk); check("b_lat_k1", 32'(s_axil_bvalid), 1);
    @(posedge clk); #1; drain("t1_write");

    // Read latency: rvalid first after edge k+RL
    s_axil_araddr = 16'h0100; s_axil_arvalid = 1;
    @(posedge clk); #1;
    s_axil_arvalid = 0; r_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
    for (int i = 0; i < RL; i++) begin
      @(negedge clk); check($sformatf("r_lat_%0d", i), 32'(s_axil_rvalid), 0);
    end
    @(negedge clk); check("r_lat_ready", 32'(s_axil_rvalid), 1);
    @(posedge clk); #1; drain("t1_read");

    // Vector table
    foreach (vecs[i]) begin
      if (vecs[i].wr) write_op(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      else            read_op(vecs[i].addr, vecs[i].data, vecs[i].resp);
      drain($sformatf("vec_%0d", i));
    end

    // W ahead of AW by 5 cycles
    write_op(16'h0004, 32'h0, 4'hF, 2'b00); drain("t2_pre");
    s_axil_wdata = 32'h0000_00AA; s_axil_wstrb = 4'h1; s_axil_wvalid = 1;
    @(posedge clk); #1; s_axil_wvalid = 0;
    flag = 0;
    repeat (5) begin @(negedge clk); if (s_axil_bvalid) flag = 1; @(posedge clk); #1; end
    check("w_only_no_b", 32'(flag), 0);
    s_axil_awaddr = 16'h0004; s_axil_awvalid = 1;
    @(posedge clk); #1; s_axil_awvalid = 0; b_q.push_back(2'b00);
    drain("t2_write");
    read_op(16'h0004, 32'h0000_00AA, 2'b00); drain("t2_read");

    // Read-first collision: AR and commit on the same edge
    write_op(16'h0020, 32'h1111_1111, 4'hF, 2'b00); drain("t4_pre");
    s_axil_awaddr = 16'h0020; s_axil_wdata = 32'h2222_2222; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(posedge clk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0; b_q.push_back(2'b00);
    s_axil_araddr = 16'h0020; s_axil_arvalid = 1;
    r_q.push_back('{data: 32'h1111_1111, resp: 2'b00});
    @(posedge clk); #1; s_axil_arvalid = 0;
    drain("t4_collide");
    read_op(16'h0020, 32'h2222_2222, 2'b00); drain("t4_after");

    // 16 back-to-back reads with random rready
    for (int i = 0; i < 16; i++) begin
      write_op(16'h0040 + 16'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 2'b00);
      drain("t3_pre");
    end
    saw_full = 0; issued = 0; seen0 = r_seen;
    s_axil_araddr = 16'h0040; s_axil_arvalid = 1;
    for (int c = 0; c < 400 && (issued < 16 || r_q.size() != 0); c++) begin
      #2;
      ostd = issued - (r_seen - seen0);
      if (ostd > RL + 1) check("t3_outstanding", 32'(ostd), RL + 1);
      if (ostd >= RL + 1 && !(s_axil_rvalid && s_axil_rready)) begin
        saw_full = 1;
        check("t3_arready_full", 32'(s_axil_arready), 0);
      end
      fire = s_axil_arvalid && s_axil_arready;
      @(posedge clk); #1;
      if (fire) begin
        r_q.push_back('{data: 32'hA000_0000 + 32'(issued), resp: 2'b00});
        issued++;
        s_axil_araddr = 16'h0040 + 16'(4*issued);
        if (issued == 16) s_axil_arvalid = 0;
      end
      s_axil_rready = 1'($urandom_range(0, 1));
    end
    s_axil_rready = 1;
    s_axil_arvalid = 0;
    drain("t3_burst");
    check("t3_issued", 32'(issued), 16);
    check("t3_responses", 32'(r_seen - seen0), 16);
    check("t3_full_seen", 32'(saw_full), 1);

    // Reset with B pending and two reads in flight
    s_axil_bready = 0; s_axil_rready = 0;
    write_op(16'h0030, 32'h3C3C_3C3C, 4'hF, 2'b00);
    s_axil_araddr = 16'h0100; s_axil_arvalid = 1;
    @(posedge clk); #1; s_axil_araddr = 16'h0104;
    @(posedge clk); #1; s_axil_arvalid = 0;
    check("t6_b_pending", 32'(s_axil_bvalid), 1);
    #2 rst_n = 0;
    #1;
    check("t6_bvalid", 32'(s_axil_bvalid), 0);
    check("t6_rvalid", 32'(s_axil_rvalid), 0);
    check("t6_awready", 32'(s_axil_awready), 0);
    check("t6_arready", 32'(s_axil_arready), 0);
    b_q.delete(); r_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    s_axil_bready = 1; s_axil_rready = 1;
    @(posedge clk); #1;
    flag = 0;
    repeat (8) begin @(negedge clk); if (s_axil_rvalid || s_axil_bvalid) flag = 1; end
    check("t6_no_stale", 32'(flag), 0);
    @(posedge clk); #1;
    read_op(16'h0100, 32'hDEAD_BEEF, 2'b00); drain("t6_r1");
    read_op(16'h0030, 32'h3C3C_3C3C, 2'b00); drain("t6_r2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
